// File: rtl/rx_block.sv
// rx_block: UART serial receiver, OVERSAMPLE clk16 cycles per bit.
// Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
//
// Ports:
//   clk16          in   sampling clock, OVERSAMPLE x baud, rising edge
//   rst_n          in   synchronous active-low reset
//   serial_data_in in   asynchronous serial line, idle high
//   receive_flag   out  one-cycle pulse when para_data_out takes a new frame
//   para_data_out  out  last correctly received byte, held between frames
//
// FSM states:
//   state     | meaning
//   IDLE      | line idle, waiting for a low level on rx_s
//   START     | counting to the start-bit mid-point to reject glitches
//   DATA      | sampling the 8 data bits, one per bit period
//   STOP      | sampling the stop bit; deliver byte if it is high
//   WAIT_HIGH | framing error / break, wait for the line to return high
//
// OVERSAMPLE must be even and >= 4.

module rx_block #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk16,
  input  logic       rst_n,
  input  logic       serial_data_in,
  output logic       receive_flag,
  output logic [7:0] para_data_out
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state, state_d;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [7:0]      shift, shift_d;
  logic [7:0]      data_d;
  logic            flag_d;

  always_ff @(posedge clk16) begin
    if (!rst_n) begin
      // Synchronizer presets to the idle level so reset release never looks
      // like a start edge.
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      receive_flag  <= 1'b0;
      para_data_out <= 8'h00;
    end else begin
      rx_meta       <= serial_data_in;
      rx_s          <= rx_meta;
      state         <= state_d;
      cnt           <= cnt_d;
      bit_idx       <= bit_idx_d;
      shift         <= shift_d;
      receive_flag  <= flag_d;
      para_data_out <= data_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    data_d    = para_data_out;
    flag_d    = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CNT_MID) begin
          if (!rx_s) begin
            // From here on, cnt wraps at CNT_END so every later sample lands
            // at the middle of its bit.
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CNT_END) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end

      STOP: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CNT_END) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift;
            flag_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_HIGH;
          end
        end
      end

      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rx_block.sv
// Testbench for rx_block. Frames are driven on negedges of clk16; each
// transmitted frame pushes its byte and the clk16 edge count at which the
// flag must appear; a monitor pops and compares on every receive_flag.

module tb_rx_block;

  localparam int OS        = 16;
  localparam int FLAG_EDGE = 3 + OS / 2 + 9 * OS;   // 155 for OS = 16

  typedef struct {
    logic [7:0] data;
    int         at_edge;
  } exp_t;

  logic       clk16 = 1'b0;
  logic       rst_n;
  logic       line;
  logic       receive_flag;
  logic [7:0] para_data_out;

  int   tests      = 0;
  int   fails      = 0;
  int   edge_cnt   = 0;
  int   flags_seen = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  rx_block #(.OVERSAMPLE(OS)) dut (
    .clk16          (clk16),
    .rst_n          (rst_n),
    .serial_data_in (line),
    .receive_flag   (receive_flag),
    .para_data_out  (para_data_out)
  );

  always #5 clk16 = ~clk16;

  always @(posedge clk16) edge_cnt++;

  always @(negedge clk16) begin
    if (receive_flag === 1'b1) begin
      flags_seen++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_flag: got flag with data %h at edge %0d, expected no flag",
                 para_data_out, edge_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        if (para_data_out !== mon_e.data) begin
          fails++;
          $display("FAIL rx_data: got %h expected %h", para_data_out, mon_e.data);
        end
        tests++;
        if (edge_cnt != mon_e.at_edge) begin
          fails++;
          $display("FAIL flag_timing: got edge %0d expected edge %0d",
                   edge_cnt, mon_e.at_edge);
        end
      end
    end
  end

  // Called on a negedge; returns on the negedge that ends the stop bit.
  task automatic send_frame(input logic [7:0] b);
    exp_t e;
    e.data    = b;
    e.at_edge = edge_cnt + FLAG_EDGE;
    exp_q.push_back(e);
    line = 1'b0;
    repeat (OS) @(negedge clk16);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (OS) @(negedge clk16);
    end
    line = 1'b1;
    repeat (OS) @(negedge clk16);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    line  = 1'b1;
    @(posedge clk16);
    @(negedge clk16);
    tests++;
    if (receive_flag !== 1'b0 || para_data_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_in: got flag %b data %h expected flag 0 data 00",
               receive_flag, para_data_out);
    end
    @(posedge clk16);
    @(negedge clk16);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk16);
      tests++;
      if (receive_flag !== 1'b0 || para_data_out !== 8'h00) begin
        fails++;
        $display("FAIL reset_idle: got flag %b data %h expected flag 0 data 00",
                 receive_flag, para_data_out);
      end
    end
  endtask

  task automatic test_single_frame();
    // Line falls at t=50; flag due at edge 155 of the frame (t=1595).
    send_frame(8'h59);
    repeat (4) @(negedge clk16);
    tests++;
    if (para_data_out !== 8'h59) begin
      fails++;
      $display("FAIL single_hold: got %h expected 59", para_data_out);
    end
  endtask

  task automatic test_framing_error();
    line = 1'b0;
    repeat (200) @(negedge clk16);
    tests++;
    if (para_data_out !== 8'h59) begin
      fails++;
      $display("FAIL break_low: got %h expected 59", para_data_out);
    end
    line = 1'b1;
    repeat (200) @(negedge clk16);
    tests++;
    if (para_data_out !== 8'h59) begin
      fails++;
      $display("FAIL break_release: got %h expected 59", para_data_out);
    end
    send_frame(8'hA5);
    repeat (4) @(negedge clk16);
    tests++;
    if (para_data_out !== 8'hA5) begin
      fails++;
      $display("FAIL after_break: got %h expected a5", para_data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    seq[0] = 8'h00;
    seq[1] = 8'hFF;
    seq[2] = 8'h3C;
    for (int i = 0; i < 3; i++) send_frame(seq[i]);
    repeat (4) @(negedge clk16);
    tests++;
    if (para_data_out !== 8'h3C) begin
      fails++;
      $display("FAIL b2b_last: got %h expected 3c", para_data_out);
    end
  endtask

  task automatic test_false_start();
    line = 1'b0;
    repeat (4) @(negedge clk16);
    line = 1'b1;
    repeat (200) @(negedge clk16);
    tests++;
    if (para_data_out !== 8'h3C) begin
      fails++;
      $display("FAIL false_start: got %h expected 3c", para_data_out);
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] pb;
    pb   = 8'hC3;
    line = 1'b0;
    repeat (OS) @(negedge clk16);
    for (int i = 0; i < 4; i++) begin
      line = pb[i];
      repeat (OS) @(negedge clk16);
    end
    line = pb[4];
    repeat (OS / 2) @(negedge clk16);
    rst_n = 1'b0;
    line  = 1'b1;
    repeat (2) @(negedge clk16);
    tests++;
    if (receive_flag !== 1'b0 || para_data_out !== 8'h00) begin
      fails++;
      $display("FAIL midreset_out: got flag %b data %h expected flag 0 data 00",
               receive_flag, para_data_out);
    end
    rst_n = 1'b1;
    repeat (200) @(negedge clk16);
    tests++;
    if (para_data_out !== 8'h00) begin
      fails++;
      $display("FAIL midreset_idle: got %h expected 00", para_data_out);
    end
    send_frame(8'h81);
    repeat (4) @(negedge clk16);
    tests++;
    if (para_data_out !== 8'h81) begin
      fails++;
      $display("FAIL midreset_next: got %h expected 81", para_data_out);
    end
  endtask

  task automatic test_drain();
    repeat (50) @(negedge clk16);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_flags: got %0d frames unflagged expected 0", exp_q.size());
    end
    tests++;
    if (flags_seen != 6) begin
      fails++;
      $display("FAIL flag_count: got %0d expected 6", flags_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_framing_error();
    test_back_to_back();
    test_false_start();
    test_mid_frame_reset();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_block.md
# rx_block

UART serial receiver sampling an asynchronous line with a clock at 16× the baud rate. It detects a start bit, samples eight data bits LSB-first at mid-bit and checks the stop bit. Each valid frame is delivered as a parallel byte with a one-cycle strobe. It sits between the external RX pin and the byte-level consumer, such as a FIFO or command parser.

## Interface
- OVERSAMPLE, 16: clk16 cycles per bit; must be even and ≥ 4.
- clk16  input  1  sampling clock at OVERSAMPLE × baud rate; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- serial_data_in  input  1  asynchronous serial line; idle high. Frame is 1 start (0), 8 data (LSB first), 1 stop (1).
- receive_flag  output  1  one-cycle pulse when para_data_out is updated with a valid frame.
- para_data_out  output  8  last correctly received byte; held until the next valid frame.

## Operation
- Input path: 2-flop synchronizer on serial_data_in; its output is rx_s. All decisions use rx_s only.
- Counter cnt is a 4-bit bit-period counter (width log2(OVERSAMPLE)). A 3-bit data-bit index tracks the eight data bits. An 8-bit shift register assembles the byte, LSB first: each sampled bit enters at bit 7 and the register shifts right.
- FSM states:
  - IDLE: rx_s==0 → START, cnt=0.
  - START: cnt increments each cycle. At cnt==OVERSAMPLE/2−1 (start mid-point):
    - rx_s==0 → DATA, cnt=0, index=0.
    - rx_s==1 → false start, back to IDLE; no output change.
  - DATA: cnt increments each cycle. At cnt==OVERSAMPLE−1, sample rx_s into the shift register and set cnt=0. After the 8th sample → STOP.
  - STOP: same counting. At cnt==OVERSAMPLE−1, sample rx_s:
    - 1 → load para_data_out from the shift register, pulse receive_flag, go to IDLE.
    - 0 → framing error: no flag, para_data_out unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then IDLE. This prevents a held-low line (break) from retriggering frames.
- Reset (rst_n==0 at a clk16 edge), from any state including mid-frame:
  - FSM→IDLE; cnt, index and shift register cleared.
  - Synchronizer flops set to 1.
  - receive_flag=0, para_data_out=8'h00.
  - Any partial frame is discarded.
- Outputs are registered. receive_flag is high for exactly one clk16 cycle per valid frame and never high in any other state.

## Timing
- Number clk16 rising edges from the first edge after serial_data_in falls (edge 1).
- Edge 3: FSM enters START.
- Edge 11: start mid-point check.
- Edge 11+16·(k+1): data bit k sampled, k=0..7.
- Edge 155: stop bit sampled. On a valid stop, receive_flag and para_data_out change at this edge; flag is high only until edge 156.
- These edge numbers are for OVERSAMPLE=16. Generally, start check = edge 3+OVERSAMPLE/2 and stop sample = edge 3+OVERSAMPLE/2+9·OVERSAMPLE.
- A new start edge is accepted from the first IDLE cycle. Back-to-back frames whose stop bit lasts one bit period must be received without loss.
- Glitches low shorter than about OVERSAMPLE/2 cycles are rejected by the start mid-point check.

## Test plan
- Reset then idle: clk16 period 10 ns, rst_n low for 2 edges, line high → receive_flag=0 and para_data_out=8'h00 throughout.
- Single frame: bit period 160 ns. Start 0 at t=50, then data 1,0,0,1,1,0,1,0, then stop 1 → one receive_flag pulse at edge 155 (t=1595 ns) and para_data_out=8'h59.
- Framing error/break: immediately after the previous frame, drive the line low and hold it → no flag; para_data_out stays 8'h59; FSM parks in WAIT_HIGH. Once the line returns high, the next frame 8'hA5 is received correctly.
- Back-to-back frames 8'h00, 8'hFF, 8'h3C with one stop bit each → three flag pulses exactly 160 cycles apart and correct data each time.
- False start: 40 ns low pulse on an idle line → no flag, no data change, FSM back in IDLE.
- Mid-frame reset: assert rst_n low during data bit 4 of a frame, release, then send 8'h81 → outputs 0 after reset, the partial frame is never flagged, and 8'h81 is received correctly.
